demux4_reg: RTL and testbench

DEMUX4_REG -- requirements
Module: demux4_reg

---
 rtl/demux4_reg.sv | 66 ++++++
 tb/tb_demux4_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready buffer per lane.
// The selected lane can be drained and refilled on the same edge without a bubble.
module demux4_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       s,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       y_valid,
   input  logic [3:0]       y_ready,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [7:0]       xfer_cnt
);

   logic [3:0]       vld;
   logic [WIDTH-1:0] lane_buf [4];
   logic             accept;

   // A full lane may still accept if its consumer empties it on this same edge.
   assign in_ready = ~flush & (~vld[s] | y_ready[s]);
   assign accept   = in_valid & in_ready;

   assign y_valid = vld;
   assign y0      = lane_buf[0];
   assign y1      = lane_buf[1];
   assign y2      = lane_buf[2];
   assign y3      = lane_buf[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld <= '0;
         // NOTE: the data buffers are reset too, because the lane outputs must read zero after reset.
         for (int i = 0; i < 4; i++) begin
            lane_buf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            // NOTE: non-blocking assignments, so every lane sees pre-edge state regardless of loop order.
            if (flush) begin
               vld[i] <= 1'b0;
            end else if (accept && (s == i[1:0])) begin
               vld[i]      <= 1'b1;
               lane_buf[i] <= d;
            end else if (vld[i] && y_ready[i]) begin
               vld[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xfer_cnt <= '0;
      end else if (accept) begin
         xfer_cnt <= xfer_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_demux4_reg.sv
// Directed self-checking bench for demux4_reg: handshake, stall isolation,
// back-to-back refill, flush, counter wrap and asynchronous reset.
module tb_demux4_reg;

   localparam int WIDTH = 32;

   logic             clk;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       s;
   logic [WIDTH-1:0] d;
   logic [3:0]       y_valid;
   logic [3:0]       y_ready;
   logic [WIDTH-1:0] y0, y1, y2, y3;
   logic [7:0]       xfer_cnt;

   int checks = 0;
   int errors = 0;

   demux4_reg #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .s        (s),
      .d        (d),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .xfer_cnt (xfer_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge, then settle away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] lane(input int i);
      case (i)
         0:       return y0;
         1:       return y1;
         2:       return y2;
         default: return y3;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; s = 2'd0; d = '0; y_ready = 4'b0000;
      step(); step();
      reset = 1'b0;
      #1;
      checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL reset_y_valid got %b want 0000", y_valid); end
      checks++; if ({y0, y1, y2, y3} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h %h want zeros", y0, y1, y2, y3); end
      checks++; if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", xfer_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      in_valid = 1'b1; s = 2'd2; d = 32'hDEADBEEF; y_ready = 4'b0000;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", in_ready); end
      step();
      checks++; if (y_valid !== 4'b0100) begin errors++; $display("FAIL single_y_valid got %b want 0100", y_valid); end
      checks++; if (y2 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_y2 got %h want deadbeef", y2); end
      checks++; if (xfer_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", xfer_cnt); end
      d = 32'h11111111;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", in_ready); end
      step();
      checks++; if (y2 !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_y2 got %h want deadbeef", y2); end
      checks++; if (y_valid !== 4'b0100) begin errors++; $display("FAIL stall_y_valid got %b want 0100", y_valid); end
      checks++; if (xfer_cnt !== 8'd1) begin errors++; $display("FAIL stall_cnt got %0d want 1", xfer_cnt); end
   endtask

   task automatic test_back_to_back();
      y_ready = 4'b0100; d = 32'h12345678;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
      step();
      checks++; if (y_valid !== 4'b0100) begin errors++; $display("FAIL b2b_y_valid got %b want 0100", y_valid); end
      checks++; if (y2 !== 32'h12345678) begin errors++; $display("FAIL b2b_y2 got %h want 12345678", y2); end
      checks++; if (xfer_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d want 2", xfer_cnt); end
      in_valid = 1'b0;
      step();
      checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL drain_y_valid got %b want 0000", y_valid); end
      y_ready = 4'b0000;
   endtask

   task automatic test_no_hol();
      in_valid = 1'b1; s = 2'd0; d = 32'h0BADF00D; y_ready = 4'b0000;
      step();
      checks++; if (y_valid !== 4'b0001) begin errors++; $display("FAIL hol_fill_y_valid got %b want 0001", y_valid); end
      s = 2'd3; d = 32'hA5A5A5A5;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hol_ready got %b want 1", in_ready); end
      step();
      checks++; if (y_valid !== 4'b1001) begin errors++; $display("FAIL hol_y_valid got %b want 1001", y_valid); end
      checks++; if (y0 !== 32'h0BADF00D) begin errors++; $display("FAIL hol_y0 got %h want 0badf00d", y0); end
      checks++; if (y3 !== 32'hA5A5A5A5) begin errors++; $display("FAIL hol_y3 got %h want a5a5a5a5", y3); end
      checks++; if (xfer_cnt !== 8'd4) begin errors++; $display("FAIL hol_cnt got %0d want 4", xfer_cnt); end
      s = 2'd0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hol_full_ready got %b want 0", in_ready); end
   endtask

   task automatic test_idle_ignored();
      // Idle input with junk select/data plus ready on an empty lane: nothing moves.
      in_valid = 1'b0; s = 2'd1; d = 32'hFFFFFFFF; y_ready = 4'b0010;
      step();
      checks++; if (y_valid !== 4'b1001) begin errors++; $display("FAIL idle_y_valid got %b want 1001", y_valid); end
      checks++; if (y1 !== 32'h0) begin errors++; $display("FAIL idle_y1 got %h want 0", y1); end
      checks++; if (xfer_cnt !== 8'd4) begin errors++; $display("FAIL idle_cnt got %0d want 4", xfer_cnt); end
      y_ready = 4'b0000;
   endtask

   task automatic test_flush();
      in_valid = 1'b1; s = 2'd1; d = 32'h11110001;
      step();
      s = 2'd2; d = 32'h22220002;
      step();
      checks++; if (y_valid !== 4'b1111) begin errors++; $display("FAIL flush_pre_y_valid got %b want 1111", y_valid); end
      checks++; if (xfer_cnt !== 8'd6) begin errors++; $display("FAIL flush_pre_cnt got %0d want 6", xfer_cnt); end
      flush = 1'b1; s = 2'd1; d = 32'hFFFFFFFF;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
      step();
      checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL flush_y_valid got %b want 0000", y_valid); end
      checks++; if (xfer_cnt !== 8'd6) begin errors++; $display("FAIL flush_cnt got %0d want 6", xfer_cnt); end
      checks++; if (y1 !== 32'h11110001) begin errors++; $display("FAIL flush_y1 got %h want 11110001", y1); end
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready got %b want 1", in_ready); end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] exp_d;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      checks++; if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL wrap_start_cnt got %0d want 0", xfer_cnt); end
      y_ready = 4'b1111; in_valid = 1'b1;
      for (int k = 0; k < 256; k++) begin
         exp_d = 32'hC0DE0000 | WIDTH'(k);
         s = 2'(k); d = exp_d;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready[%0d] got %b want 1", k, in_ready); end
         step();
         checks++; if (y_valid !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL wrap_y_valid[%0d] got %b want %b", k, y_valid, 4'b0001 << (k % 4)); end
         checks++; if (lane(k % 4) !== exp_d) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", k, lane(k % 4), exp_d); end
         checks++; if (xfer_cnt !== 8'(k + 1)) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", k, xfer_cnt, 8'(k + 1)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL wrap_end_y_valid got %b want 0000", y_valid); end
      checks++; if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL wrap_end_cnt got %0d want 0", xfer_cnt); end
      y_ready = 4'b0000;
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; y_ready = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         s = 2'(i); d = 32'h5A000000 | WIDTH'(i);
         step();
      end
      in_valid = 1'b0;
      checks++; if (y_valid !== 4'b1111) begin errors++; $display("FAIL areset_pre_y_valid got %b want 1111", y_valid); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL areset_y_valid got %b want 0000", y_valid); end
      checks++; if ({y0, y1, y2, y3} !== '0) begin errors++; $display("FAIL areset_data got %h %h %h %h want zeros", y0, y1, y2, y3); end
      checks++; if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", xfer_cnt); end
      reset = 1'b0;
      in_valid = 1'b1; s = 2'd1; d = 32'h00000077;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", in_ready); end
      step();
      checks++; if (y_valid !== 4'b0010) begin errors++; $display("FAIL areset_after_y_valid got %b want 0010", y_valid); end
      checks++; if (y1 !== 32'h00000077) begin errors++; $display("FAIL areset_after_y1 got %h want 00000077", y1); end
      checks++; if (xfer_cnt !== 8'd1) begin errors++; $display("FAIL areset_after_cnt got %0d want 1", xfer_cnt); end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_no_hol();
      test_idle_ignored();
      test_flush();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
